rstgen_seq: RTL
===============

// Module: rstgen_seq
// PURPOSE
// Reset generator for one clock domain: synchronises deassertion of an asynchronous active-high reset,
// then releases NumOut downstream reset outputs one stage at a time, StageDelay cycles apart.
// Test-mode bypass routes the external test reset straight to every output. Sits at the SoC/cluster
// reset root, ahead of interconnect, then cores, then peripherals.
// PARAMETERS
// NumRegs    4   synchroniser depth in flops; >= 2
// NumOut     4   number of staged reset outputs; >= 1
// StageDelay 16  cycles between consecutive stage releases (also sw-reset hold time); >= 1
// CntWidth   $clog2(StageDelay+1)  derived, not to be overridden
// PORTS
// clk_i             in   1       clock
// rst_i             in   1       asynchronous reset, active-high
// test_mode_i       in   1       1 = bypass mode
// rst_test_mode_ni  in   1       active-low reset used in bypass mode
// sw_rst_req_i      in   1       software re-sequence request (level, held until ack)
// sw_rst_ack_o      out  1       one-cycle pulse: sw request accepted, outputs re-releasing
// rst_no            out  NumOut  active-low stage resets; bit 0 releases first
// init_no           out  1       active-low, deasserts when synchroniser output goes high
// done_o            out  1       1 when all stages released (state RUN)
// BEHAVIOUR
// - Assertion async: rst_i=1 -> same instant rst_no='0, init_no=0, done_o=0, sw_rst_ack_o=0,
//   sync chain cleared, FSM=RESET, counter=0, stage index=0. Applies in every state (mid-sequence too).
// - Deassertion sync: chain shifts in 1; init_no goes high on the NumRegs-th rising edge after rst_i falls.
// - FSM RESET -> REL when chain output high; counter starts at 0.
// - REL: counter increments each cycle; at StageDelay-1 it wraps to 0, rst_no[idx] set to 1, idx++.
//   Releasing idx=NumOut-1 -> RUN. rst_no[k] high exactly NumRegs+(k+1)*StageDelay edges after rst_i falls.
// - Released stages stay high; unreleased stay low; bits never toggle out of order.
// - RUN: done_o=1, holds until rst_i or sw request.
// - All outputs registered, glitch-free; no combinational path from sw_rst_req_i to outputs.
// - Bypass (test_mode_i=1): internal async reset = ~rst_test_mode_ni; every rst_no bit = rst_test_mode_ni,
//   init_no=1, done_o=rst_test_mode_ni, sw_rst_ack_o=0. All muxing via tc_clk_mux2 cells.
// - test_mode_i is static; changing it outside reset is unsupported.
// - Elaboration fatal if NumRegs<2, NumOut<1 or StageDelay<1.
// CONFIGURATION
// RSTGEN_SEQ_SW_RST_EN defined: extra state DRAIN. In RUN with sw_rst_req_i=1: next edge rst_no='0,
//   done_o=0, counter=0, FSM=DRAIN; hold StageDelay cycles, then sw_rst_ack_o=1 for one cycle, idx=0,
//   FSM=REL (normal staged release). init_no unaffected. sw_rst_req_i ignored outside RUN.
//   Requester drops request after ack; request still high one cycle after ack is ignored until RUN.
// Not defined: no DRAIN state, sw_rst_req_i unused, sw_rst_ack_o tied 0; ports remain.
// TESTING (NumRegs=4, NumOut=3, StageDelay=5 unless stated)
// 1 rst_i 1->0 at edge 0 -> init_no=1 at edge 4; rst_no=001 @9, 011 @14, 111 @19; done_o=1 @19.
// 2 rst_i pulsed high at edge 12 (mid-REL) -> rst_no=000, done_o=0 immediately; full sequence restarts.
// 3 test_mode_i=1, toggle rst_test_mode_ni -> rst_no follows 000/111 with no clock; init_no stays 1.
// 4 SW_RST_EN, RUN, sw_rst_req_i=1 at edge 30 -> rst_no=000 @31, ack pulse @36, rst_no=111 @51, done_o=1 @51.
// 5 SW_RST_EN off, sw_rst_req_i=1 in RUN -> outputs unchanged, sw_rst_ack_o stays 0.
// 6 StageDelay=1, NumOut=1 -> rst_no[0]=1 one edge after init_no rises; done_o same edge.

Source files
------------

// File: rtl/rstgen_seq.sv
// Staged reset generator: synchronises release of rst_i, then frees rst_no[0..NumOut-1] StageDelay cycles apart.
// Optional software re-sequence (DRAIN state) is enabled by defining RSTGEN_SEQ_SW_RST_EN.

module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);
    assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

module rstgen_seq #(
    parameter int unsigned NumRegs    = 4,
    parameter int unsigned NumOut     = 4,
    parameter int unsigned StageDelay = 16,
    localparam int unsigned CntWidth  = $clog2(StageDelay + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_mode_i,
    input  logic              rst_test_mode_ni,
    input  logic              sw_rst_req_i,
    output logic              sw_rst_ack_o,
    output logic [NumOut-1:0] rst_no,
    output logic              init_no,
    output logic              done_o
);
    localparam int unsigned IdxWidth = (NumOut > 1) ? $clog2(NumOut) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(StageDelay - 1);
    localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(NumOut - 1);

    if (NumRegs < 2) begin : g_bad_regs
        $fatal(1, "rstgen_seq: NumRegs must be >= 2");
    end
    if (NumOut < 1) begin : g_bad_out
        $fatal(1, "rstgen_seq: NumOut must be >= 1");
    end
    if (StageDelay < 1) begin : g_bad_delay
        $fatal(1, "rstgen_seq: StageDelay must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_REL   = 2'd1,
        ST_RUN   = 2'd2
`ifdef RSTGEN_SEQ_SW_RST_EN
        ,
        ST_DRAIN = 2'd3
`endif
    } state_e;

    state_e              state_q;
    logic [NumRegs-1:0]  sync_q;
    logic [CntWidth-1:0] cnt_q;
    logic [IdxWidth-1:0] idx_q;
    logic [NumOut-1:0]   rst_q;
    logic                done_q;
    logic                ack_q;
    logic                rst_test;
    logic                rst_int;

    // In bypass the test reset drives the whole block asynchronously.
    assign rst_test = ~rst_test_mode_ni;
    tc_clk_mux2 i_rst_mux (
        .clk0_i    (rst_i),
        .clk1_i    (rst_test),
        .clk_sel_i (test_mode_i),
        .clk_o     (rst_int)
    );

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NumRegs-2:0], 1'b1};
        end
    end

    // Leaving RESET keys off the chain's next output so the first stage frees
    // StageDelay edges after init_no rises.
    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_RESET: begin
                    if (sync_q[NumRegs-2]) begin
                        state_q <= ST_REL;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                ST_REL: begin
                    if (cnt_q == CntLast) begin
                        cnt_q        <= '0;
                        rst_q[idx_q] <= 1'b1;
                        if (idx_q == IdxLast) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    done_q <= 1'b1;
`ifdef RSTGEN_SEQ_SW_RST_EN
                    if (sw_rst_req_i) begin
                        state_q <= ST_DRAIN;
                        rst_q   <= '0;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
`endif
                end
`ifdef RSTGEN_SEQ_SW_RST_EN
                ST_DRAIN: begin
                    if (cnt_q == CntLast) begin
                        ack_q   <= 1'b1;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_REL;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: state_q <= ST_RESET;
            endcase
        end
    end

`ifndef RSTGEN_SEQ_SW_RST_EN
    logic unused_sw_req;
    assign unused_sw_req = sw_rst_req_i;
`endif

    for (genvar i = 0; i < NumOut; i++) begin : g_out_mux
        tc_clk_mux2 i_rst_no_mux (
            .clk0_i    (rst_q[i]),
            .clk1_i    (rst_test_mode_ni),
            .clk_sel_i (test_mode_i),
            .clk_o     (rst_no[i])
        );
    end

    tc_clk_mux2 i_init_mux (
        .clk0_i    (sync_q[NumRegs-1]),
        .clk1_i    (1'b1),
        .clk_sel_i (test_mode_i),
        .clk_o     (init_no)
    );

    tc_clk_mux2 i_done_mux (
        .clk0_i    (done_q),
        .clk1_i    (rst_test_mode_ni),
        .clk_sel_i (test_mode_i),
        .clk_o     (done_o)
    );

    tc_clk_mux2 i_ack_mux (
        .clk0_i    (ack_q),
        .clk1_i    (1'b0),
        .clk_sel_i (test_mode_i),
        .clk_o     (sw_rst_ack_o)
    );

endmodule
